// File: rtl/serdes_rr_arbiter_if.sv
// Bus bundle between upstream lane sources, the arbiter and the downstream byte sink.
interface serdes_rr_arbiter_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CH_W   = 2,
  parameter int unsigned DATA_W = 8
);
  logic [NUM_CH*DATA_W-1:0] req_data_i;
  logic [NUM_CH-1:0]        req_valid_i;
  logic [NUM_CH-1:0]        req_ready_o;
  logic [DATA_W-1:0]        data_o;
  logic [CH_W-1:0]          ch_o;
  logic                     valid_o;
  logic                     ready_i;
  logic [NUM_CH-1:0]        grant_o;
  logic                     busy_o;

  // Arbiter view
  modport slave (
    input  req_data_i, req_valid_i, ready_i,
    output req_ready_o, data_o, ch_o, valid_o, grant_o, busy_o
  );

  // Source/sink view
  modport master (
    output req_data_i, req_valid_i, ready_i,
    input  req_ready_o, data_o, ch_o, valid_o, grant_o, busy_o
  );
endinterface

// File: rtl/serdes_rr_arbiter.sv
// Round-robin burst arbiter merging NUM_CH byte lanes into one registered byte stream.
module serdes_rr_arbiter #(
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CH_W      = 2,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  serdes_rr_arbiter_if.slave   bus
);
  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    S_IDLE    = 3'b001,
    S_BURST   = 3'b010,
    S_RELEASE = 3'b100
  } state_t;

  state_t              state, state_n;
  logic [NUM_CH-1:0]   grant, grant_n;
  logic [CH_W-1:0]     last_grant, last_grant_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic [CH_W-1:0]     pick;
  logic                pick_found;
  logic [DATA_W-1:0]   data;
  logic [CH_W-1:0]     ch;
  logic                valid;
  logic                can_load;
  logic                cur_valid;
  logic                load;

  // Rotating-priority search starting just above the last granted channel
  always_comb begin
    int unsigned idx;
    idx        = 0;
    pick       = last_grant;
    pick_found = 1'b0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      idx = (32'(last_grant) + i) % NUM_CH;
      if (!pick_found && bus.req_valid_i[idx]) begin
        pick       = CH_W'(idx);
        pick_found = 1'b1;
      end
    end
  end

  // Beat acceptance: last_grant doubles as the id of the channel currently granted
  always_comb begin
    can_load  = !valid || bus.ready_i;
    cur_valid = bus.req_valid_i[last_grant];
    load      = (state == S_BURST) && cur_valid && can_load;
    bus.req_ready_o = (state == S_BURST && can_load) ? grant : '0;
  end

  // State and grant registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      grant      <= '0;
      last_grant <= CH_W'(NUM_CH - 1);
      cnt        <= '0;
    end else begin
      state      <= state_n;
      grant      <= grant_n;
      last_grant <= last_grant_n;
      cnt        <= cnt_n;
    end
  end

  // Next-state: arbitrate, count burst beats, force one dead cycle on release
  always_comb begin
    state_n      = state;
    grant_n      = grant;
    last_grant_n = last_grant;
    cnt_n        = cnt;
    unique case (state)
      S_IDLE: begin
        grant_n = '0;
        if (pick_found) begin
          grant_n      = NUM_CH'(1) << pick;
          last_grant_n = pick;
          cnt_n        = '0;
          state_n      = S_BURST;
        end
      end
      S_BURST: begin
        if (!cur_valid) begin
          grant_n = '0;
          cnt_n   = '0;
          state_n = S_RELEASE;
        end else if (load) begin
          cnt_n = cnt + CNT_W'(1);
          if ((cnt + CNT_W'(1)) == CNT_W'(MAX_BURST)) begin
            grant_n = '0;
            cnt_n   = '0;
            state_n = S_RELEASE;
          end
        end
      end
      S_RELEASE: begin
        grant_n = '0;
        cnt_n   = '0;
        state_n = S_IDLE;
      end
      default: begin
        grant_n = '0;
        cnt_n   = '0;
        state_n = S_IDLE;
      end
    endcase
  end

  // One-entry output stage; drains independently of the arbitration state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data  <= '0;
      ch    <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= bus.req_data_i[32'(last_grant)*DATA_W +: DATA_W];
      ch    <= last_grant;
      valid <= 1'b1;
    end else if (bus.ready_i) begin
      valid <= 1'b0;
    end
  end

  assign bus.data_o  = data;
  assign bus.ch_o    = ch;
  assign bus.valid_o = valid;
  assign bus.grant_o = grant;
  assign bus.busy_o  = (state != S_IDLE);

endmodule

// File: tb/tb_serdes_rr_arbiter.sv
// Directed bench for serdes_rr_arbiter: per-channel byte sources plus an in-order scoreboard.
module tb_serdes_rr_arbiter;
  logic clk;
  logic rst;

  serdes_rr_arbiter_if #(.NUM_CH(4), .CH_W(2), .DATA_W(8)) bus ();

  serdes_rr_arbiter #(.NUM_CH(4), .CH_W(2), .DATA_W(8), .MAX_BURST(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;

  logic [7:0] src_bytes [4][16];
  int         src_len [4];
  int         src_ptr [4];
  int         sb_ptr  [4];

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [1:0] c;
    logic [3:0] g;
    logic       b;
  } vec_t;

  vec_t t1 [11];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_inputs();
    for (int k = 0; k < 4; k++) begin
      bus.req_valid_i[k] = (src_ptr[k] < src_len[k]);
      bus.req_data_i[k*8 +: 8] = (src_ptr[k] < 16) ? src_bytes[k][src_ptr[k]] : 8'h00;
    end
  endtask

  task automatic clear_src();
    for (int k = 0; k < 4; k++) begin
      src_len[k] = 0;
      src_ptr[k] = 0;
      sb_ptr[k]  = 0;
      for (int j = 0; j < 16; j++) src_bytes[k][j] = 8'h00;
    end
  endtask

  task automatic set_src(input int k, input int base, input int len);
    src_len[k] = len;
    for (int j = 0; j < 16; j++) src_bytes[k][j] = 8'(base + j);
  endtask

  // One clock: capture handshakes at negedge, advance sources after posedge
  task automatic tick();
    logic [3:0] hs;
    @(negedge clk);
    hs = bus.req_ready_o & bus.req_valid_i;
    if (!rst && bus.valid_o && bus.ready_i) begin
      chk("sb_data", int'(bus.data_o), int'(src_bytes[bus.ch_o][sb_ptr[bus.ch_o]]));
      sb_ptr[bus.ch_o]++;
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) if (hs[k]) src_ptr[k]++;
    drive_inputs();
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_valid"}, int'(bus.valid_o), 0);
    chk({tag, "_data"},  int'(bus.data_o), 0);
    chk({tag, "_ch"},    int'(bus.ch_o), 0);
    chk({tag, "_grant"}, int'(bus.grant_o), 0);
    chk({tag, "_busy"},  int'(bus.busy_o), 0);
    chk({tag, "_rdy"},   int'(bus.req_ready_o), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.ready_i = 1'b1;
    clear_src();
    drive_inputs();
    tick();
    tick();
    check_idle_outputs("reset");
  endtask

  task automatic release_reset();
    drive_inputs();
    rst = 1'b0;
  endtask

  task automatic check_sb(input string tag);
    for (int k = 0; k < 4; k++) chk({tag, "_sb_count"}, sb_ptr[k], src_ptr[k]);
  endtask

  initial begin
    logic [3:0] grants [$];
    logic [3:0] prev_g;
    logic [3:0] exp_g [5];
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b1;
    bus.ready_i = 1'b1;
    bus.req_valid_i = '0;
    bus.req_data_i = '0;

    // expected per-cycle outputs for the sole-requester burst/rotation case
    t1[0]  = '{1'b0, 8'h00, 2'd0, 4'b0100, 1'b1};
    t1[1]  = '{1'b1, 8'h10, 2'd2, 4'b0100, 1'b1};
    t1[2]  = '{1'b1, 8'h11, 2'd2, 4'b0100, 1'b1};
    t1[3]  = '{1'b1, 8'h12, 2'd2, 4'b0100, 1'b1};
    t1[4]  = '{1'b1, 8'h13, 2'd2, 4'b0000, 1'b1};
    t1[5]  = '{1'b0, 8'h00, 2'd0, 4'b0000, 1'b0};
    t1[6]  = '{1'b0, 8'h00, 2'd0, 4'b0100, 1'b1};
    t1[7]  = '{1'b1, 8'h14, 2'd2, 4'b0100, 1'b1};
    t1[8]  = '{1'b1, 8'h15, 2'd2, 4'b0100, 1'b1};
    t1[9]  = '{1'b0, 8'h00, 2'd0, 4'b0000, 1'b1};
    t1[10] = '{1'b0, 8'h00, 2'd0, 4'b0000, 1'b0};

    // Test 1: sole requester, forced release after MAX_BURST, regrant
    do_reset();
    set_src(2, 8'h10, 6);
    release_reset();
    for (int i = 0; i < 11; i++) begin
      tick();
      chk($sformatf("t1_valid[%0d]", i), int'(bus.valid_o), int'(t1[i].v));
      chk($sformatf("t1_grant[%0d]", i), int'(bus.grant_o), int'(t1[i].g));
      chk($sformatf("t1_busy[%0d]", i),  int'(bus.busy_o),  int'(t1[i].b));
      if (t1[i].v) begin
        chk($sformatf("t1_data[%0d]", i), int'(bus.data_o), int'(t1[i].d));
        chk($sformatf("t1_ch[%0d]", i),   int'(bus.ch_o),   int'(t1[i].c));
      end
    end
    check_sb("t1");

    // Test 2: all channels busy, grant rotates 0,1,2,3,0 with 4 beats each
    do_reset();
    for (int k = 0; k < 4; k++) set_src(k, 8'h20 + 8'(k * 32), 16);
    release_reset();
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0010; exp_g[2] = 4'b0100;
    exp_g[3] = 4'b1000; exp_g[4] = 4'b0001;
    prev_g = 4'b0000;
    for (int i = 0; i < 29; i++) begin
      tick();
      if (bus.grant_o != 4'b0000 && prev_g == 4'b0000) grants.push_back(bus.grant_o);
      prev_g = bus.grant_o;
    end
    chk("t2_num_grants", grants.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < grants.size()) chk($sformatf("t2_grant[%0d]", i), int'(grants[i]), int'(exp_g[i]));
    chk("t2_beats_ch0", src_ptr[0], 8);
    chk("t2_beats_ch1", src_ptr[1], 4);
    chk("t2_beats_ch2", src_ptr[2], 4);
    chk("t2_beats_ch3", src_ptr[3], 4);
    tick();
    check_sb("t2");

    // Test 3: downstream stall holds the output byte stable
    do_reset();
    set_src(1, 8'hA5, 4);
    release_reset();
    tick();
    chk("t3_grant", int'(bus.grant_o), 4'b0010);
    tick();
    chk("t3_first", int'(bus.data_o), 8'hA5);
    bus.ready_i = 1'b0;
    #1;
    chk("t3_rdy_drop", int'(bus.req_ready_o), 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t3_hold_data[%0d]", i),  int'(bus.data_o), 8'hA5);
      chk($sformatf("t3_hold_ch[%0d]", i),    int'(bus.ch_o), 1);
      chk($sformatf("t3_hold_valid[%0d]", i), int'(bus.valid_o), 1);
      chk($sformatf("t3_hold_rdy[%0d]", i),   int'(bus.req_ready_o), 0);
    end
    bus.ready_i = 1'b1;
    tick();
    chk("t3_resume", int'(bus.data_o), 8'hA6);
    tick();
    chk("t3_resume2", int'(bus.data_o), 8'hA7);
    tick();
    tick();
    tick();
    check_sb("t3");

    // Test 4: granted channel drops valid; next search starts above it
    do_reset();
    set_src(0, 8'h40, 2);
    set_src(3, 8'h70, 4);
    release_reset();
    tick();
    chk("t4_grant0", int'(bus.grant_o), 4'b0001);
    tick();
    tick();
    chk("t4_beat2", int'(bus.data_o), 8'h41);
    tick();
    chk("t4_rel_grant", int'(bus.grant_o), 0);
    chk("t4_rel_busy", int'(bus.busy_o), 1);
    tick();
    chk("t4_idle_busy", int'(bus.busy_o), 0);
    tick();
    chk("t4_grant3", int'(bus.grant_o), 4'b1000);
    tick();
    chk("t4_ch3_data", int'(bus.data_o), 8'h70);
    chk("t4_ch3_tag", int'(bus.ch_o), 3);
    for (int i = 0; i < 4; i++) tick();
    check_sb("t4");

    // Test 5: reset mid-burst discards the held byte and restarts priority at 0
    do_reset();
    set_src(1, 8'h50, 8);
    release_reset();
    tick();
    tick();
    tick();
    chk("t5_pre_valid", int'(bus.valid_o), 1);
    chk("t5_pre_grant", int'(bus.grant_o), 4'b0010);
    rst = 1'b1;
    set_src(0, 8'h30, 4);
    set_src(2, 8'h60, 4);
    tick();
    check_idle_outputs("t5_rst");
    for (int k = 0; k < 4; k++) sb_ptr[k] = src_ptr[k];
    rst = 1'b0;
    tick();
    chk("t5_grant0", int'(bus.grant_o), 4'b0001);
    tick();
    chk("t5_data", int'(bus.data_o), 8'h30);
    chk("t5_ch", int'(bus.ch_o), 0);

    // Test 6: back-to-back drain and load keeps valid high with no loss
    do_reset();
    set_src(0, 8'h80, 4);
    release_reset();
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t6_valid[%0d]", i), int'(bus.valid_o), 1);
      chk($sformatf("t6_data[%0d]", i),  int'(bus.data_o), 8'h80 + i);
    end
    tick();
    chk("t6_drained", int'(bus.valid_o), 0);
    chk("t6_src_count", src_ptr[0], 4);
    check_sb("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/serdes_rr_arbiter.md
Name: serdes_rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream byte stream between NUM_CH upstream byte sources, e.g. several SIPO deserializer lanes feeding one PISO serializer or one shared FIFO write port.
- Grants one channel at a time for a bounded burst.
- Registers the selected byte in a one-entry output stage tagged with its channel id.
- Sits between the lane deserializers and the shared serializer/FIFO in the SERDES datapath.

Parameters:
NUM_CH, 4, number of requesting channels (2..8)
CH_W, 2, width of channel id, equals ceil(log2(NUM_CH))
DATA_W, 8, byte width per channel
MAX_BURST, 4, maximum beats per grant before forced rotation (1..15)

Ports:
clk_i  input  1  single clock, all logic on posedge
rst_i  input  1  synchronous, active-high reset
req_data_i  input  NUM_CH*DATA_W  channel k data at bits [k*DATA_W +: DATA_W]
req_valid_i  input  NUM_CH  per-channel data valid
req_ready_o  output  NUM_CH  per-channel accept (combinational)
data_o  output  DATA_W  registered output byte
ch_o  output  CH_W  channel id of data_o
valid_o  output  1  output stage holds a byte
ready_i  input  1  downstream accept
grant_o  output  NUM_CH  one-hot current grant, registered
busy_o  output  1  high whenever state is not S_IDLE

Behaviour:
- Interface: one clock (clk_i); reset rst_i is synchronous and active-high.
- Reset: data_o=0, ch_o=0, valid_o=0, grant_o=0, busy_o=0, req_ready_o=0, beat counter=0, state=S_IDLE, last_grant=NUM_CH-1 (first pick is channel 0). Reset mid-burst discards any held output byte.
- Handshakes:
  - A transfer on either side occurs at a posedge with valid and ready both high.
  - Output stage can load when empty (valid_o=0) or being drained in the same cycle (valid_o & ready_i).
  - req_ready_o[g] = grant_o[g] & state==S_BURST & output stage can load. All other bits are 0.
  - data_o and ch_o stay stable while valid_o=1 and ready_i=0.
- One-hot FSM, states S_IDLE=3'b001, S_BURST=3'b010, S_RELEASE=3'b100:
  - S_IDLE: if any req_valid_i is set, pick the first valid channel searching upward from last_grant+1 with wrap modulo NUM_CH. Set grant_o one-hot, last_grant=pick, beat counter=0, go to S_BURST. Otherwise stay with grant_o=0.
  - S_BURST: each accepted beat loads data_o with the granted channel's byte, sets ch_o=granted id and valid_o=1, and increments the counter.
    - Go to S_RELEASE when an accepted beat makes the counter equal MAX_BURST.
    - Also go to S_RELEASE when req_valid_i[g]=0 in any cycle (no beat that cycle).
  - S_RELEASE: grant_o=0, counter=0, no acceptance, next state S_IDLE. Result: exactly one dead cycle between release and the next arbitration cycle.
- Throughput: 1 byte/clk within a burst while ready_i=1. Grant-to-first-accept latency is 1 cycle after the S_IDLE decision.
- A sole requester is re-granted after a forced release (S_RELEASE, S_IDLE, S_BURST).
- Output drain is independent of state: valid_o clears on ready_i when no new load occurs. A simultaneous drain and load keeps valid_o=1 with the new byte.
- A channel dropping req_valid_i while granted loses the grant. It has no priority boost on return.
- Counter width is 4 bits, compared with MAX_BURST, no overflow possible.

Test Plan:
1. NUM_CH=4, MAX_BURST=4. Only channel 2 valid with bytes 0x10..0x15, ready_i=1. Expect bytes 0x10..0x13 with ch_o=2 on consecutive cycles, a 2-cycle gap (RELEASE, IDLE), then 0x14,0x15.
2. All four channels continuously valid, ready_i=1. Grant_o sequence 0001, 0010, 0100, 1000, 0001. Each grant delivers 4 beats, ch_o tags correct.
3. Channel 1 granted, ready_i low for 5 cycles after the first beat 0xA5. Expect data_o=0xA5, ch_o=1, valid_o=1 held stable and req_ready_o=0000 throughout; streaming resumes on ready_i rise.
4. Channel 0 drops req_valid_i after 2 beats while channel 3 is valid. Expect release; the next grant goes to channel 3 (search starts at 1, channels 1-2 idle).
5. Assert rst_i for one cycle mid-burst with valid_o=1. Next cycle: all outputs 0, state S_IDLE; first post-reset grant goes to channel 0 if valid.
6. Simultaneous drain and load with ready_i=1 throughout a burst. valid_o never drops between beats 1..4 and no byte is duplicated or lost (scoreboard compare).
